spi_flash_id_reader: RTL and testbench
======================================

Name: spi_flash_id_reader

Overview:
- SPI master that issues the JEDEC Read-ID command (0x9F) to the on-board serial flash and captures the three returned ID bytes.
- Sits directly upstream of the LED selection mux. Its manufacture_id, memory_type and memory_capacity outputs feed the mux's identically named inputs.
- A read is triggered by a start pulse, typically from a debounced push-button or a power-up one-shot.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 1..255.
- CMD_RDID, 8'h9F: command byte shifted out.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- start  input  1  request a read; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse when new ID bytes are loaded.
- valid  output  1  set at first done; stays set until reset.
- no_device  output  1  valid && manufacture_id is 8'h00 or 8'hFF.
- manufacture_id  output  8  ID byte 1.
- memory_type  output  8  ID byte 2.
- memory_capacity  output  8  ID byte 3.
- spi_cs_n  output  1  flash chip select, active low.
- spi_sck  output  1  SPI clock, mode 0 (idle low).
- spi_mosi  output  1  master data out, MSB first.
- spi_miso  input  1  flash data in.

Behaviour:
- Reset (reset==0) outputs, next clk:
  - spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - busy=0, done=0, valid=0, no_device=0.
  - All ID bytes = 8'h00.
  - State = IDLE.
- Reset mid-transaction aborts immediately; the flash sees CS deassert.
- Timing units: half-period counter hc runs 0..CLK_DIV-1. Bit counter bc runs 0..31.
- States:
  - IDLE:
    - spi_cs_n=1, SCK=0.
    - On start==1: go to SETUP; busy=1 from the next cycle.
  - SETUP (CLK_DIV cycles):
    - spi_cs_n=0, SCK=0, spi_mosi=CMD_RDID[7].
    - Go to SHIFT.
  - SHIFT (32 bits × 2·CLK_DIV cycles). Each bit is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
    - spi_miso is sampled on the clk edge that ends the high phase (the same edge that drives SCK low).
    - On that same edge spi_mosi updates:
      - to CMD_RDID[6-bc] for bc 0..6;
      - to 0 from bc 7 onward.
    - MISO bits for bc 0..7 are discarded. Bits bc 8..31 shift into a 24-bit register, MSB first.
    - After the bc=31 low phase, go to HOLD.
  - HOLD (CLK_DIV cycles):
    - spi_cs_n=0, SCK=0.
    - Go to DONE.
  - DONE (1 cycle):
    - spi_cs_n=1.
    - manufacture_id=shreg[23:16], memory_type=shreg[15:8], memory_capacity=shreg[7:0].
    - done=1, valid=1.
    - Go to RECOVER.
  - RECOVER (CLK_DIV cycles):
    - spi_cs_n=1, busy=1; start is ignored.
    - Go to IDLE (busy=0).
- Latency: start sampled at cycle T0 → done high at T0+1+66·CLK_DIV (T265 for CLK_DIV=4). busy falls at T0+2+67·CLK_DIV.
- start while busy: ignored, not queued. start held high continuously: a new read begins on the first IDLE cycle.
- ID outputs, valid and no_device hold their previous values during a new read; they change only in DONE.
- no_device is registered and updated in DONE together with the bytes.
- CLK_DIV=1 is supported:
  - SCK = clk/2.
  - Counter width must hold CLK_DIV-1 without wrap.

Test Plan:
- Nominal read (CLK_DIV=4): flash model returns EF 40 18; pulse start at T0.
  - MOSI carries 1001_1111 on the first 8 SCK rising edges.
  - 32 SCK pulses total; CS low for 66·4 cycles.
  - done pulses at T265 with EF/40/18; valid=1, no_device=0.
- start re-pulsed at T50 and T200 during the read: no extra SCK pulses, a single done pulse, byte values unchanged from the nominal case.
- Reset asserted during SHIFT at bc=12:
  - next cycle CS=1, SCK=0, busy=0, outputs 00/00/00, valid=0.
  - A following start gives a clean full read.
- spi_miso tied high: bytes FF/FF/FF, no_device=1. Then the model returns C2 20 17: no_device=0 after the next done.
- CLK_DIV=1, start held high: back-to-back reads.
  - SCK period 2 clk.
  - CS high for at least 2 cycles (DONE+RECOVER) between frames.
  - done every 69 cycles with correct bytes.
- Second read returning different bytes (EF 40 18 → 20 BA 19): outputs keep EF/40/18 until the second done, then switch in one cycle.

Source files
------------

// File: rtl/spi_flash_id_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_id_reader_if
// Description : Bundles the request/status handshake, the three captured
//               JEDEC ID bytes and the four-wire SPI bus of the flash ID
//               reader.
//               master : view used by spi_flash_id_reader itself.
//               slave  : view used by the surrounding logic / flash side.
// Signals     : start           - read request (into reader)
//               busy            - read in progress
//               done            - one-cycle pulse, new ID bytes loaded
//               valid           - at least one read has completed
//               no_device       - valid and manufacture ID is 00 or FF
//               manufacture_id  - ID byte 1
//               memory_type     - ID byte 2
//               memory_capacity - ID byte 3
//               spi_cs_n        - flash chip select, active low
//               spi_sck         - SPI clock, mode 0
//               spi_mosi        - master data out
//               spi_miso        - flash data in
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_id_reader_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       valid;
    logic       no_device;
    logic [7:0] manufacture_id;
    logic [7:0] memory_type;
    logic [7:0] memory_capacity;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (
        input  start,
        input  spi_miso,
        output busy,
        output done,
        output valid,
        output no_device,
        output manufacture_id,
        output memory_type,
        output memory_capacity,
        output spi_cs_n,
        output spi_sck,
        output spi_mosi
    );

    modport slave (
        output start,
        output spi_miso,
        input  busy,
        input  done,
        input  valid,
        input  no_device,
        input  manufacture_id,
        input  memory_type,
        input  memory_capacity,
        input  spi_cs_n,
        input  spi_sck,
        input  spi_mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_id_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_id_reader
// Description : SPI mode-0 master that sends the JEDEC Read-ID command and
//               captures the three returned ID bytes. Frame layout:
//               SETUP (CLK_DIV) -> 32 SCK bits (2*CLK_DIV each) ->
//               HOLD (CLK_DIV) -> DONE (1) -> RECOVER (CLK_DIV) -> IDLE.
// Parameters  : CLK_DIV  - clk cycles per SCK half-period (1..255)
//               CMD_RDID - command byte shifted out MSB first
// Ports       : clk   - system clock, rising edge
//               reset - synchronous reset, active low
//               bus   - spi_flash_id_reader_if.master (handshake, ID bytes,
//                       SPI pins)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_id_reader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [7:0]  CMD_RDID = 8'h9F
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    spi_flash_id_reader_if.master         bus
);

    // Half-period counter must reach CLK_DIV-1; keep at least one bit so
    // CLK_DIV=1 still gets a legal vector.
    localparam int unsigned    HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SHIFT   = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic [4:0]        bc_q, bc_d;
    logic              low_ph_q, low_ph_d;   // 0: SCK high phase, 1: low phase
    logic              mosi_q, mosi_d;
    logic [23:0]       shreg_q, shreg_d;
    logic [7:0]        mid_q, mid_d;
    logic [7:0]        mtype_q, mtype_d;
    logic [7:0]        mcap_q, mcap_d;
    logic              valid_q, valid_d;
    logic              nodev_q, nodev_d;

    logic              hc_last;
    logic [2:0]        cmd_idx;

    assign hc_last = (hc_q == HC_LAST);
    // Command bit driven after the high phase of bit bc is bit 6-bc; only
    // meaningful for bc 0..6, the mux below selects 0 otherwise.
    assign cmd_idx = 3'(5'd6 - bc_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            hc_q     <= '0;
            bc_q     <= '0;
            low_ph_q <= 1'b0;
            mosi_q   <= 1'b0;
            shreg_q  <= '0;
            mid_q    <= '0;
            mtype_q  <= '0;
            mcap_q   <= '0;
            valid_q  <= 1'b0;
            nodev_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            bc_q     <= bc_d;
            low_ph_q <= low_ph_d;
            mosi_q   <= mosi_d;
            shreg_q  <= shreg_d;
            mid_q    <= mid_d;
            mtype_q  <= mtype_d;
            mcap_q   <= mcap_d;
            valid_q  <= valid_d;
            nodev_q  <= nodev_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        bc_d     = bc_q;
        low_ph_d = low_ph_q;
        mosi_d   = mosi_q;
        shreg_d  = shreg_q;
        mid_d    = mid_q;
        mtype_d  = mtype_q;
        mcap_d   = mcap_q;
        valid_d  = valid_q;
        nodev_d  = nodev_q;

        case (state_q)
            S_IDLE: begin
                hc_d   = '0;
                mosi_d = 1'b0;
                if (bus.start) begin
                    state_d = S_SETUP;
                    // First command bit must be stable before the first
                    // SCK rising edge.
                    mosi_d  = CMD_RDID[7];
                end
            end

            S_SETUP: begin
                if (hc_last) begin
                    state_d  = S_SHIFT;
                    hc_d     = '0;
                    bc_d     = '0;
                    low_ph_d = 1'b0;
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end

            S_SHIFT: begin
                if (!hc_last) begin
                    hc_d = hc_q + HC_ONE;
                end else begin
                    hc_d = '0;
                    if (!low_ph_q) begin
                        // End of high phase: SCK falls, sample MISO and
                        // advance MOSI on the same edge.
                        low_ph_d = 1'b1;
                        if (bc_q >= 5'd8) begin
                            shreg_d = {shreg_q[22:0], bus.spi_miso};
                        end
                        mosi_d = (bc_q <= 5'd6) ? CMD_RDID[cmd_idx] : 1'b0;
                    end else begin
                        low_ph_d = 1'b0;
                        if (bc_q == 5'd31) begin
                            state_d = S_HOLD;
                        end else begin
                            bc_d = bc_q + 5'd1;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (hc_last) begin
                    state_d = S_DONE;
                    hc_d    = '0;
                    // Bytes and flags become visible in the DONE cycle.
                    mid_d   = shreg_q[23:16];
                    mtype_d = shreg_q[15:8];
                    mcap_d  = shreg_q[7:0];
                    valid_d = 1'b1;
                    nodev_d = (shreg_q[23:16] == 8'h00) ||
                              (shreg_q[23:16] == 8'hFF);
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end

            S_DONE: begin
                state_d = S_RECOVER;
                hc_d    = '0;
            end

            S_RECOVER: begin
                if (hc_last) begin
                    state_d = S_IDLE;
                    hc_d    = '0;
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                hc_d    = '0;
            end
        endcase
    end

    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.valid           = valid_q;
    assign bus.no_device       = nodev_q;
    assign bus.manufacture_id  = mid_q;
    assign bus.memory_type     = mtype_q;
    assign bus.memory_capacity = mcap_q;
    assign bus.spi_cs_n        = !((state_q == S_SETUP) ||
                                   (state_q == S_SHIFT) ||
                                   (state_q == S_HOLD));
    assign bus.spi_sck         = (state_q == S_SHIFT) && !low_ph_q;
    assign bus.spi_mosi        = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_id_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_id_reader
// Description : Directed self-checking bench for spi_flash_id_reader with a
//               CLK_DIV=4 instance and a CLK_DIV=1 instance, each attached to
//               a mode-0 JEDEC flash model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_id_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    spi_flash_id_reader_if if4 ();
    spi_flash_id_reader_if if1 ();

    spi_flash_id_reader #(.CLK_DIV(4), .CMD_RDID(8'h9F)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    spi_flash_id_reader #(.CLK_DIV(1), .CMD_RDID(8'h9F)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // ---------------- flash models: new bit presented on SCK rise ----------
    logic [23:0] id4, id1;
    logic        tie4;
    int          cnt4 = 0;
    int          cnt1 = 0;

    always @(posedge if4.spi_sck or posedge if4.spi_cs_n) begin
        if (if4.spi_cs_n) begin
            cnt4 = 0;
            if4.spi_miso = 1'b0;
        end else begin
            if4.spi_miso = tie4 ? 1'b1 : ((cnt4 >= 8) ? id4[31-cnt4] : 1'b0);
            cnt4++;
        end
    end

    always @(posedge if1.spi_sck or posedge if1.spi_cs_n) begin
        if (if1.spi_cs_n) begin
            cnt1 = 0;
            if1.spi_miso = 1'b0;
        end else begin
            if1.spi_miso = (cnt1 >= 8) ? id1[31-cnt1] : 1'b0;
            cnt1++;
        end
    end

    // ---------------- bus monitors (sampled on falling clk) ----------------
    logic        sck_prev4  = 1'b0;
    int          sck_rises4 = 0;
    int          cs_low4    = 0;
    int          done_cnt4  = 0;
    logic [31:0] mosi_hist4 = '0;

    always @(negedge clk) begin
        if (if4.spi_sck === 1'b1 && !sck_prev4) begin
            sck_rises4++;
            mosi_hist4 = {mosi_hist4[30:0], if4.spi_mosi};
        end
        sck_prev4 = (if4.spi_sck === 1'b1);
        if (if4.spi_cs_n === 1'b0) cs_low4++;
        if (if4.done === 1'b1) done_cnt4++;
    end

    logic sck_prev1  = 1'b0;
    int   sck_rises1 = 0;
    int   ncyc1      = 0;
    int   last_rise1 = -1;
    int   bad_gap1   = 0;
    int   hi_run1    = 0;
    int   frames1    = 0;
    int   min_gap1   = 1000;

    always @(negedge clk) begin
        ncyc1++;
        if (if1.spi_sck === 1'b1 && !sck_prev1) begin
            sck_rises1++;
            if (last_rise1 >= 0 && (ncyc1 - last_rise1) != 2) bad_gap1++;
            last_rise1 = ncyc1;
        end
        sck_prev1 = (if1.spi_sck === 1'b1);
        if (if1.spi_cs_n === 1'b1) begin
            hi_run1++;
            last_rise1 = -1;
        end else if (if1.spi_cs_n === 1'b0 && hi_run1 > 0) begin
            if (frames1 > 0 && hi_run1 < min_gap1) min_gap1 = hi_run1;
            frames1++;
            hi_run1 = 0;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ids4();
        return {if4.manufacture_id, if4.memory_type, if4.memory_capacity};
    endfunction

    // Start one read on the CLK_DIV=4 instance. k counts falling edges after
    // the rising edge that samples start (k=1 is the first SETUP cycle).
    // Optional extra start pulses are raised at k=rp_a / k=rp_b.
    task automatic do_read4(input int rp_a, input int rp_b,
                            output int done_at, output int busy_fall,
                            output logic [23:0] pre_ids, output logic [23:0] done_ids);
        done_at   = -1;
        busy_fall = -1;
        pre_ids   = '0;
        done_ids  = '0;
        if4.start = 1'b1;
        for (int k = 1; k <= 400 && busy_fall < 0; k++) begin
            @(negedge clk);
            if4.start = (k == rp_a) || (k == rp_b);
            if (done_at < 0) begin
                if (if4.done === 1'b1) begin
                    done_at  = k;
                    done_ids = ids4();
                end else begin
                    pre_ids = ids4();
                end
            end else if (if4.busy === 1'b0) begin
                busy_fall = k;
            end
        end
        if4.start = 1'b0;
    endtask

    // ---------------- directed sequence ------------------------------------
    int          d_at, b_fall, s_r, s_cs, s_d, rises, n;
    logic [23:0] pre, at_done;
    logic        prev, found;
    int          dones[4];

    initial begin
        reset     = 1'b0;
        if4.start = 1'b0;
        if1.start = 1'b0;
        id4       = 24'hEF4018;
        id1       = 24'hEF4018;
        tie4      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst4_ctl", {if4.spi_cs_n, if4.spi_sck, if4.spi_mosi, if4.busy,
                           if4.done, if4.valid, if4.no_device}, 32'h40);
        check("rst4_ids", ids4(), 24'h000000);
        check("rst1_ctl", {if1.spi_cs_n, if1.spi_sck, if1.spi_mosi, if1.busy,
                           if1.done, if1.valid, if1.no_device}, 32'h40);
        reset = 1'b1;
        @(negedge clk);

        // Nominal read, EF 40 18
        s_r = sck_rises4; s_cs = cs_low4; s_d = done_cnt4;
        do_read4(0, 0, d_at, b_fall, pre, at_done);
        check("nom_done_at",   d_at, 265);
        check("nom_busy_fall", b_fall, 270);
        check("nom_done_ids",  at_done, 24'hEF4018);
        check("nom_ids",       ids4(), 24'hEF4018);
        check("nom_flags",     {if4.valid, if4.no_device}, 32'h2);
        check("nom_sck_rises", sck_rises4 - s_r, 32);
        check("nom_mosi",      mosi_hist4, 32'h9F00_0000);
        check("nom_cs_low",    cs_low4 - s_cs, 264);
        check("nom_done_cnt",  done_cnt4 - s_d, 1);

        // start re-pulsed during the read
        s_r = sck_rises4; s_d = done_cnt4;
        do_read4(50, 200, d_at, b_fall, pre, at_done);
        check("rp_done_at",   d_at, 265);
        check("rp_sck_rises", sck_rises4 - s_r, 32);
        check("rp_done_cnt",  done_cnt4 - s_d, 1);
        check("rp_ids",       ids4(), 24'hEF4018);

        // Second read returning different bytes
        id4 = 24'h20BA19;
        do_read4(0, 0, d_at, b_fall, pre, at_done);
        check("sw_pre_ids",  pre, 24'hEF4018);
        check("sw_done_ids", at_done, 24'h20BA19);
        check("sw_done_at",  d_at, 265);

        // Reset during SHIFT at bc=12 (13th SCK high phase)
        id4 = 24'hEF4018;
        s_d = done_cnt4; rises = 0; prev = 1'b0; found = 1'b0;
        if4.start = 1'b1;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if4.start = 1'b0;
            if (if4.spi_sck === 1'b1 && !prev) rises++;
            prev = (if4.spi_sck === 1'b1);
            if (rises == 13) found = 1'b1;
        end
        check("abort_reached", found, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ctl", {if4.spi_cs_n, if4.spi_sck, if4.busy, if4.valid,
                            if4.no_device}, 32'h10);
        check("abort_ids", ids4(), 24'h000000);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_done", done_cnt4 - s_d, 0);
        do_read4(0, 0, d_at, b_fall, pre, at_done);
        check("after_abort_done_at", d_at, 265);
        check("after_abort_ids",     ids4(), 24'hEF4018);
        check("after_abort_flags",   {if4.valid, if4.no_device}, 32'h2);

        // MISO tied high, then a real device again
        tie4 = 1'b1;
        do_read4(0, 0, d_at, b_fall, pre, at_done);
        check("tie_ids",   ids4(), 24'hFFFFFF);
        check("tie_flags", {if4.valid, if4.no_device}, 32'h3);
        tie4 = 1'b0;
        id4  = 24'hC22017;
        do_read4(0, 0, d_at, b_fall, pre, at_done);
        check("mx_ids",   ids4(), 24'hC22017);
        check("mx_flags", {if4.valid, if4.no_device}, 32'h2);

        // CLK_DIV=1, start held high: back-to-back reads
        s_r = sck_rises1; n = 0;
        if1.start = 1'b1;
        for (int k = 1; k <= 400 && n < 4; k++) begin
            @(negedge clk);
            if (if1.done === 1'b1) begin
                dones[n] = k;
                check("cd1_ids", {if1.manufacture_id, if1.memory_type,
                                  if1.memory_capacity}, 24'hEF4018);
                n++;
            end
        end
        if1.start = 1'b0;
        check("cd1_done_count", n, 4);
        if (n == 4) begin
            check("cd1_first_done", dones[0], 67);
            for (int i = 1; i < 4; i++) check("cd1_done_period", dones[i] - dones[i-1], 69);
        end
        check("cd1_sck_rises", sck_rises1 - s_r, 128);
        check("cd1_sck_period", bad_gap1, 0);
        check("cd1_cs_high_gap", min_gap1, 3);
        check("cd1_flags", {if1.valid, if1.no_device}, 32'h2);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
